// File: rtl/onchip_mem_loader.sv
// onchip_mem_loader: Avalon-MM write master that packs a byte stream
// little-endian into 32-bit words, writes them to on-chip RAM starting at a
// commanded word address, keeps a 16-bit byte checksum and can read the
// region back to verify that checksum.
`timescale 1ns/1ps
module onchip_mem_loader #(
    parameter int ADDR_W = 15,
    parameter int DEPTH  = 32000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_start,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [16:0]       cmd_len,
    input  logic              cmd_verify,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata,
    output logic              busy,
    output logic              done,
    output logic              err_range,
    output logic              err_verify,
    output logic [15:0]       sum
);
    // Word counters must hold N = ceil(4*DEPTH/4) plus one for the verify tail.
    localparam int CW = 18;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_VERIFY, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [16:0]       len_q, len_d;
    logic              verify_q, verify_d;
    logic [CW-1:0]     nwords_q, nwords_d;
    logic [16:0]       cnt_q, cnt_d;        // bytes accepted so far
    logic [CW-1:0]     widx_q, widx_d;      // next word index to write
    logic [CW-1:0]     vcyc_q, vcyc_d;      // cycles spent in VERIFY
    logic [31:0]       pack_q, pack_d;      // packer; the output regs hold the write
    logic              fill_end_q, fill_end_d;
    logic [15:0]       check_q, check_d;
    logic [15:0]       sum_q, sum_d;
    logic              s_ready_q, s_ready_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [3:0]        mem_byteenable_q, mem_byteenable_d;
    logic              mem_chipselect_q, mem_chipselect_d;
    logic              mem_write_q, mem_write_d;
    logic [31:0]       mem_writedata_q, mem_writedata_d;
    logic              mem_clken_q, mem_clken_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_range_q, err_range_d;
    logic              err_verify_q, err_verify_d;

    logic [31:0] cmd_words;
    logic        cmd_bad;
    logic [3:0]  last_be;
    logic        accept;
    logic [1:0]  lane;
    logic        is_last;
    logic [31:0] pack_ins;
    logic [3:0]  rd_mask;
    logic [15:0] chk_nxt;

    assign accept = s_valid & s_ready_q;

    // Command range check: empty, oversize, or running past the last RAM word.
    always_comb begin
        cmd_words = (32'(cmd_len) + 32'd3) >> 2;
        cmd_bad   = (cmd_len == 17'd0) || (32'(cmd_len) > 32'(4 * DEPTH))
                 || ((32'(cmd_base) + cmd_words) > 32'(DEPTH));
    end

    // Lane mask of the final word, derived from the latched length.
    always_comb begin
        case (len_q[1:0])
            2'd1:    last_be = 4'b0001;
            2'd2:    last_be = 4'b0011;
            2'd3:    last_be = 4'b0111;
            default: last_be = 4'b1111;
        endcase
    end

    // Next-state and next-output computation for the whole controller.
    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        len_d            = len_q;
        verify_d         = verify_q;
        nwords_d         = nwords_q;
        cnt_d            = cnt_q;
        widx_d           = widx_q;
        vcyc_d           = vcyc_q;
        pack_d           = pack_q;
        fill_end_d       = fill_end_q;
        check_d          = check_q;
        sum_d            = sum_q;
        s_ready_d        = s_ready_q;
        mem_address_d    = mem_address_q;
        mem_byteenable_d = 4'h0;
        mem_chipselect_d = 1'b0;
        mem_write_d      = 1'b0;
        mem_writedata_d  = mem_writedata_q;
        mem_clken_d      = 1'b1;
        done_d           = 1'b0;
        err_range_d      = err_range_q;
        err_verify_d     = err_verify_q;
        lane             = cnt_q[1:0];
        is_last          = (cnt_q == len_q - 17'd1);
        pack_ins         = pack_q | (32'(s_data) << {lane, 3'b000});
        rd_mask          = (vcyc_q == nwords_q) ? last_be : 4'hF;
        chk_nxt          = check_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_start) begin
                    err_verify_d = 1'b0;
                    if (cmd_bad) begin
                        err_range_d = 1'b1;
                        done_d      = 1'b1;
                    end else begin
                        err_range_d = 1'b0;
                        base_d      = cmd_base;
                        len_d       = cmd_len;
                        verify_d    = cmd_verify;
                        nwords_d    = CW'(cmd_words);
                        cnt_d       = '0;
                        widx_d      = '0;
                        pack_d      = '0;
                        fill_end_d  = 1'b0;
                        sum_d       = '0;
                        s_ready_d   = 1'b1;
                        state_d     = S_FILL;
                    end
                end
            end
            S_FILL: begin
                if (fill_end_q) begin
                    // Final write is on the bus this cycle; launch verify or finish.
                    fill_end_d = 1'b0;
                    if (verify_q) begin
                        state_d          = S_VERIFY;
                        vcyc_d           = '0;
                        check_d          = '0;
                        mem_chipselect_d = 1'b1;
                        mem_byteenable_d = 4'hF;
                        mem_address_d    = base_q;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (accept) begin
                    sum_d = sum_q + 16'(s_data);
                    cnt_d = cnt_q + 17'd1;
                    if (lane == 2'd3 || is_last) begin
                        mem_write_d      = 1'b1;
                        mem_chipselect_d = 1'b1;
                        mem_writedata_d  = pack_ins;
                        mem_byteenable_d = is_last ? last_be : 4'hF;
                        mem_address_d    = base_q + ADDR_W'(widx_q);
                        widx_d           = widx_q + CW'(1);
                        pack_d           = '0;
                    end else begin
                        pack_d = pack_ins;
                    end
                    if (is_last) begin
                        s_ready_d  = 1'b0;
                        fill_end_d = 1'b1;
                    end
                end
            end
            S_VERIFY: begin
                // Read data lags its address by one cycle, so cycle j>=1 sums word j-1.
                vcyc_d = vcyc_q + CW'(1);
                if (vcyc_q != '0) begin
                    for (int i = 0; i < 4; i++) begin
                        if (rd_mask[i]) chk_nxt = chk_nxt + 16'(mem_readdata[8*i +: 8]);
                    end
                    check_d = chk_nxt;
                end
                if ((vcyc_q + CW'(1)) < nwords_q) begin
                    mem_chipselect_d = 1'b1;
                    mem_byteenable_d = 4'hF;
                    mem_address_d    = base_q + ADDR_W'(vcyc_q + CW'(1));
                end
                if (vcyc_q == nwords_q) begin
                    err_verify_d = (chk_nxt != sum_q);
                    state_d      = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        if (state_d == S_DONE) done_d = 1'b1;
    end

    // State and registered outputs; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            base_q           <= '0;
            len_q            <= '0;
            verify_q         <= 1'b0;
            nwords_q         <= '0;
            cnt_q            <= '0;
            widx_q           <= '0;
            vcyc_q           <= '0;
            pack_q           <= '0;
            fill_end_q       <= 1'b0;
            check_q          <= '0;
            sum_q            <= '0;
            s_ready_q        <= 1'b0;
            mem_address_q    <= '0;
            mem_byteenable_q <= '0;
            mem_chipselect_q <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_writedata_q  <= '0;
            mem_clken_q      <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            err_range_q      <= 1'b0;
            err_verify_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            base_q           <= base_d;
            len_q            <= len_d;
            verify_q         <= verify_d;
            nwords_q         <= nwords_d;
            cnt_q            <= cnt_d;
            widx_q           <= widx_d;
            vcyc_q           <= vcyc_d;
            pack_q           <= pack_d;
            fill_end_q       <= fill_end_d;
            check_q          <= check_d;
            sum_q            <= sum_d;
            s_ready_q        <= s_ready_d;
            mem_address_q    <= mem_address_d;
            mem_byteenable_q <= mem_byteenable_d;
            mem_chipselect_q <= mem_chipselect_d;
            mem_write_q      <= mem_write_d;
            mem_writedata_q  <= mem_writedata_d;
            mem_clken_q      <= mem_clken_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            err_range_q      <= err_range_d;
            err_verify_q     <= err_verify_d;
        end
    end

    assign s_ready        = s_ready_q;
    assign mem_address    = mem_address_q;
    assign mem_byteenable = mem_byteenable_q;
    assign mem_chipselect = mem_chipselect_q;
    assign mem_write      = mem_write_q;
    assign mem_writedata  = mem_writedata_q;
    assign mem_clken      = mem_clken_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err_range      = err_range_q;
    assign err_verify     = err_verify_q;
    assign sum            = sum_q;
endmodule

// File: tb/tb_onchip_mem_loader.sv
// Bench for onchip_mem_loader: a RAM model, a spec-level expectation list of
// writes/reads built per command, a per-cycle compare process, and directed tests.
`timescale 1ns/1ps
module tb_onchip_mem_loader;
    localparam int ADDR_W = 15;
    localparam int DEPTH  = 32000;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              cmd_start = 1'b0;
    logic [ADDR_W-1:0] cmd_base = '0;
    logic [16:0]       cmd_len = '0;
    logic              cmd_verify = 1'b0;
    logic              s_valid = 1'b0;
    logic [7:0]        s_data = '0;
    logic              s_ready;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect, mem_write, mem_clken;
    logic [31:0]       mem_writedata, mem_readdata;
    logic              busy, done, err_range, err_verify;
    logic [15:0]       sum;

    onchip_mem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_base(cmd_base),
        .cmd_len(cmd_len), .cmd_verify(cmd_verify), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_writedata(mem_writedata),
        .mem_clken(mem_clken), .mem_readdata(mem_readdata), .busy(busy), .done(done),
        .err_range(err_range), .err_verify(err_verify), .sum(sum));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    typedef struct packed {logic [14:0] addr; logic [31:0] data; logic [3:0] be;} wr_t;
    typedef struct packed {logic [14:0] addr; logic first;} rd_t;

    wr_t        exp_wr[$];   // filled by the stimulus, consumed in order by the compare
    rd_t        exp_rd[$];
    wr_t        obs_wr[$];   // every write seen on the bus, for literal checks
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         cyc = 0;
    int         last_rd_cyc = 0;
    logic [7:0] stim[$];
    bit         corrupt = 1'b0;
    bit         clk_seen = 1'b0;

    // RAM model: registered read; never-written words read back as all ones.
    logic [31:0] ram [0:DEPTH-1];
    bit          written [0:DEPTH-1];
    logic [31:0] rdata = '0;
    logic [31:0] cur;
    assign mem_readdata = rdata;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_chipselect && mem_write) begin
            cur = written[mem_address] ? ram[mem_address] : 32'hFFFF_FFFF;
            for (int i = 0; i < 4; i++)
                if (mem_byteenable[i]) cur[8*i +: 8] = mem_writedata[8*i +: 8];
            ram[mem_address]     <= cur;
            written[mem_address] <= 1'b1;
        end else if (mem_chipselect) begin
            rdata <= (written[mem_address] ? ram[mem_address] : 32'hFFFF_FFFF)
                     ^ ((corrupt && mem_address == 15'h011) ? 32'h1 : 32'h0);
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) clk_seen <= 1'b0;
        else          clk_seen <= 1'b1;
    end

    // Compare process: every bus access must match the next expected one.
    wr_t o;
    always @(negedge clk) begin
        if (reset_n) begin
            if (clk_seen) chk("mem_clken", mem_clken, 1);
            if (mem_write) chk("write_has_cs", mem_chipselect, 1);
            if (mem_chipselect && mem_write) begin
                o.addr = mem_address; o.data = mem_writedata; o.be = mem_byteenable;
                obs_wr.push_back(o);
                if (wr_ptr < exp_wr.size()) begin
                    chk("wr_addr", mem_address, exp_wr[wr_ptr].addr);
                    chk("wr_data", mem_writedata, exp_wr[wr_ptr].data);
                    chk("wr_be", mem_byteenable, exp_wr[wr_ptr].be);
                    wr_ptr++;
                end else begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: addr %h data %h, required no write",
                             mem_address, mem_writedata);
                end
            end
            if (mem_chipselect && !mem_write) begin
                chk("rd_be", mem_byteenable, 4'hF);
                if (rd_ptr < exp_rd.size()) begin
                    chk("rd_addr", mem_address, exp_rd[rd_ptr].addr);
                    if (!exp_rd[rd_ptr].first) chk("rd_back_to_back", cyc, last_rd_cyc + 1);
                    rd_ptr++;
                end else begin
                    checks++; errors++;
                    $display("FAIL unexpected_read: addr %h, required no read", mem_address);
                end
                last_rd_cyc = cyc;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_mem_bus"}, {mem_address, mem_byteenable, mem_chipselect, mem_write}, 0);
        chk({tag, "_wdata"}, mem_writedata, 0);
        chk({tag, "_clken"}, mem_clken, 0);
        chk({tag, "_status"}, {busy, done, err_range, err_verify}, 0);
        chk({tag, "_sum"}, sum, 0);
    endtask

    // Caller is at a negedge; the start pulse covers exactly one posedge.
    task automatic send_cmd(input logic [14:0] base, input int len, input bit vfy);
        cmd_start = 1'b1; cmd_base = base; cmd_len = 17'(len); cmd_verify = vfy;
        @(negedge clk);
        cmd_start = 1'b0;
    endtask

    task automatic send_bytes(input int cnt, input bit gap);
        int w;
        for (int k = 0; k < cnt; k++) begin
            s_valid = 1'b1; s_data = stim[k];
            w = 0;
            while (!s_ready && w < 50) begin @(negedge clk); w++; end
            if (w >= 50) begin
                checks++; errors++;
                $display("FAIL s_ready_timeout: byte %0d never accepted, required acceptance", k);
            end
            @(negedge clk);
            if (gap) begin s_valid = 1'b0; @(negedge clk); end
        end
        s_valid = 1'b0;
    endtask

    // Full command: build spec-level expectations, run it, check completion.
    task automatic run_cmd(input logic [14:0] base, input int len, input bit vfy,
                           input bit gap, input bit bad_rd);
        int n;
        int w;
        wr_t e;
        rd_t r;
        logic [15:0] es;
        n  = (len + 3) / 4;
        es = 16'h0;
        for (int k = 0; k < len; k++) es = es + 16'(stim[k]);
        for (int wi = 0; wi < n; wi++) begin
            e.addr = base + 15'(wi); e.data = '0; e.be = '0;
            for (int b = 0; b < 4; b++)
                if (4*wi + b < len) begin e.data[8*b +: 8] = stim[4*wi + b]; e.be[b] = 1'b1; end
            exp_wr.push_back(e);
        end
        if (vfy)
            for (int wi = 0; wi < n; wi++) begin
                r.addr = base + 15'(wi); r.first = (wi == 0); exp_rd.push_back(r);
            end
        corrupt = bad_rd;
        send_cmd(base, len, vfy);
        chk("start_busy", busy, 1);
        chk("start_s_ready", s_ready, 1);
        chk("start_errs_clear", {err_range, err_verify}, 0);
        chk("start_sum_clear", sum, 0);
        send_bytes(len, gap);
        chk("s_ready_after_last", s_ready, 0);
        w = 0;
        while (!done && w < 300) begin @(negedge clk); w++; end
        chk("done_seen", done, 1);
        chk("sum", sum, es);
        chk("err_verify", err_verify, bad_rd);
        chk("err_range_clear", err_range, 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
        chk("writes_consumed", wr_ptr, exp_wr.size());
        chk("reads_consumed", rd_ptr, exp_rd.size());
        corrupt = 1'b0;
    endtask

    task automatic range_cmd(input logic [14:0] base, input int len, input string tag);
        send_cmd(base, len, 1'b0);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_err_range"}, err_range, 1);
        chk({tag, "_busy"}, busy, 0);
        @(negedge clk);
        chk({tag, "_done_clear"}, done, 0);
        chk({tag, "_err_sticky"}, err_range, 1);
    endtask

    int n0;
    initial begin
        #1 reset_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("clken_after_release", mem_clken, 1);
        chk("idle_busy", busy, 0);

        // Two full words, no verify.
        stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        n0 = obs_wr.size();
        run_cmd(15'h010, 8, 1'b0, 1'b0, 1'b0);
        chk("t1_sum_lit", sum, 16'h0024);
        chk("t1_w0_lit", {obs_wr[n0].addr, obs_wr[n0].data, obs_wr[n0].be},
            {15'h010, 32'h04030201, 4'hF});
        chk("t1_w1_lit", {obs_wr[n0+1].addr, obs_wr[n0+1].data, obs_wr[n0+1].be},
            {15'h011, 32'h08070605, 4'hF});

        // Partial final word.
        stim = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        n0 = obs_wr.size();
        run_cmd(15'h000, 5, 1'b0, 1'b0, 1'b0);
        chk("t2_sum_lit", sum, 16'h00F0);
        chk("t2_w1_lit", {obs_wr[n0+1].addr, obs_wr[n0+1].data, obs_wr[n0+1].be},
            {15'h001, 32'h00000050, 4'h1});

        // Range faults: past end, zero length, oversize length.
        range_cmd(15'd31999, 8, "rng_end");
        range_cmd(15'h000, 0, "rng_zero");
        range_cmd(15'h000, 128001, "rng_big");

        // Verify with a good image (also clears err_range), then with a bad one.
        stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_cmd(15'h010, 8, 1'b1, 1'b0, 1'b0);
        run_cmd(15'h010, 8, 1'b1, 1'b0, 1'b1);

        // Partial word verify over unwritten (all-ones) RAM: only filled lanes count.
        stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        run_cmd(15'h030, 5, 1'b1, 1'b0, 1'b0);

        // Gappy stream.
        stim.delete();
        for (int k = 0; k < 12; k++) stim.push_back(8'hA0 + 8'(k));
        run_cmd(15'h100, 12, 1'b0, 1'b1, 1'b0);

        // Last legal words of the RAM.
        stim = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
        run_cmd(15'd31998, 8, 1'b1, 1'b0, 1'b0);

        // Reset mid-FILL after three bytes.
        stim = '{8'h01, 8'h02, 8'h03};
        send_cmd(15'h020, 8, 1'b0);
        send_bytes(3, 1'b0);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        stim = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
        run_cmd(15'h040, 4, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
